filter_stream_select: RTL and testbench
=======================================

Name: filter_stream_select

Overview:
- Parametrised streaming successor to the fixed 100x100 frame-copy filter selector.
- Accepts one pixel per beat over valid/ready, raster order, frame size IMG_W x IMG_H.
- Applies one of four per-pixel filters, selected per frame, and emits the pixel with start-of-frame, end-of-line and end-of-frame markers.
- Sits between the pixel source (memory reader / middle filter) and the display or frame writer.

Parameters:
IMG_W, 100, pixels per line (>=2)
IMG_H, 100, lines per frame (>=2)
PIX_W, 8, bits per pixel
THRESH, 128, threshold for mode 2 (compare p >= THRESH)
BRIGHT_OFS, 32, offset added in mode 3

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mode  in  2  filter select; sampled only on the first beat of a frame
in_valid  in  1  input pixel valid
in_data  in  PIX_W  input pixel
in_ready  out  1  input accepted when in_valid && in_ready
out_valid  out  1  output pixel valid
out_data  out  PIX_W  filtered pixel
out_ready  in  1  downstream ready
out_sof  out  1  marks first pixel of frame (x=0, y=0)
out_eol  out  1  marks last pixel of each line (x=IMG_W-1)
out_eof  out  1  marks last pixel of frame
busy  out  1  high in STREAM state or while out_valid
frame_cnt  out  16  frames completed, wraps at 0xFFFF -> 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; x=y=0; mode_q=0; out_valid=0; out_data=0; out_sof/eol/eof=0; frame_cnt=0. Mid-frame reset discards the partial frame; the next accepted beat is treated as sof.
- in_ready = !out_valid || out_ready (combinational; single output register, no skid buffer). Throughput is one pixel per cycle when out_ready stays high.
- Latency: an accepted input appears on out_* the next cycle.
- While out_valid && !out_ready: out_data and markers stay stable.
- FSM:
  - IDLE: on the first accepted beat, mode_q <= mode and go to STREAM. That beat is filtered with the live mode value.
  - STREAM: every beat uses mode_q. The mode input is ignored until the frame ends.
  - On the beat accepted at x=IMG_W-1, y=IMG_H-1: go to IDLE and increment frame_cnt in the same cycle.
- Counters: x increments on each accepted beat; at IMG_W-1, x wraps to 0 and y increments; at y=IMG_H-1 with x=IMG_W-1, both clear to 0.
- Markers are registered with the pixel:
  - sof = (x==0 && y==0)
  - eol = (x==IMG_W-1)
  - eof = eol && (y==IMG_H-1)
- Filter arithmetic (MAX = 2^PIX_W-1):
  - 00: passthrough.
  - 01: invert, MAX - p.
  - 10: threshold, p >= THRESH ? MAX : 0.
  - 11: brighten, p + BRIGHT_OFS computed in PIX_W+1 bits and saturated to MAX.
- No-input cycles (in_valid=0) do not advance counters; gaps of any length mid-frame are legal.

Optional Feature:
- Macro FILTER_STATS_EN. When defined, adds two output ports:
  - stat_max (PIX_W): maximum filtered pixel value of the last completed frame.
  - stat_sat (16): count of output pixels equal to MAX in that frame, saturating at 0xFFFF.
- Both update in the cycle frame_cnt increments; the per-frame accumulators clear at sof.
- Reset clears both to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=2, mode=00, stream 0..7 with out_ready=1 -> out_data 0..7, one cycle latency; sof on pixel 0; eol on 3 and 7; eof on 7; frame_cnt=1.
- mode=01 with in_data 0x00, 0x7F, 0xFF -> out 0xFF, 0x80, 0x00. Then mode=10 with 127, 128 -> 0x00, 0xFF.
- mode=11 with in_data 0xF0, 0x10 -> 0xFF (saturated), 0x30.
- Start a frame with mode=01, switch mode to 00 at pixel 2 -> all 8 pixels inverted. The next frame uses mode 00.
- Hold out_ready=0 for 3 cycles mid-frame -> in_ready=0, out_data/markers stable, no pixel lost or duplicated. Then assert rst_n=0 at pixel 5 -> outputs cleared; the next beat carries sof.
- FILTER_STATS_EN, mode=11, frame {0xF0, 0x10, 0xEF, 0, 0, 0, 0, 0} -> stat_max=0xFF, stat_sat=2 after eof.

Source files
------------

// File: rtl/filter_stream_select.sv
// Streaming per-pixel filter selector: one pixel per beat, mode latched per frame, sof/eol/eof markers.
// Optional per-frame statistics ports (stat_max, stat_sat) are enabled by defining FILTER_STATS_EN.
module filter_stream_select #(
   parameter int IMG_W      = 100,
   parameter int IMG_H      = 100,
   parameter int PIX_W      = 8,
   parameter int THRESH     = 128,
   parameter int BRIGHT_OFS = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_data,
   input  logic             out_ready,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof,
   output logic             busy,
   output logic [15:0]      frame_cnt
`ifdef FILTER_STATS_EN
   ,
   output logic [PIX_W-1:0] stat_max,
   output logic [15:0]      stat_sat
`endif
);

   // state  | meaning
   // IDLE   | waiting for the first beat of a frame; live mode filters that beat
   // STREAM | mid-frame; every beat uses the mode latched on the first beat
   typedef enum logic {S_IDLE, S_STREAM} state_t;

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [XW-1:0]    X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0]    Y_LAST = YW'(IMG_H - 1);
   localparam logic [PIX_W-1:0] MAX    = '1;

   state_t           state_q, state_d;
   logic [1:0]       mode_q;
   logic [1:0]       eff_mode;
   logic [XW-1:0]    x_q;
   logic [YW-1:0]    y_q;
   logic             accept;
   logic             x_last, y_last, frame_end, sof_beat;
   logic [PIX_W:0]   bright_sum;
   logic [PIX_W-1:0] filt;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign x_last    = (x_q == X_LAST);
   assign y_last    = (y_q == Y_LAST);
   assign sof_beat  = (x_q == '0) && (y_q == '0);
   assign frame_end = accept && x_last && y_last;
   assign busy      = (state_q == S_STREAM) || out_valid;

   always_comb begin
      state_d  = state_q;
      eff_mode = mode_q;
      case (state_q)
         S_IDLE: begin
            eff_mode = mode;
            if (accept) state_d = S_STREAM;
         end
         S_STREAM: begin
            if (frame_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Brighten sums in one extra bit so the carry flags saturation.
   assign bright_sum = {1'b0, in_data} + (PIX_W+1)'(BRIGHT_OFS);

   always_comb begin
      filt = in_data;
      case (eff_mode)
         2'b00: filt = in_data;
         2'b01: filt = MAX - in_data;
         2'b10: filt = (32'(in_data) >= THRESH) ? MAX : '0;
         2'b11: filt = bright_sum[PIX_W] ? MAX : bright_sum[PIX_W-1:0];
         default: filt = in_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         if (accept && (state_q == S_IDLE)) mode_q <= mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else if (accept) begin
         if (x_last) begin
            x_q <= '0;
            y_q <= y_last ? '0 : y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   // Single output register; pixel and markers hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_eof   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= filt;
         out_sof   <= sof_beat;
         out_eol   <= x_last;
         out_eof   <= x_last && y_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) frame_cnt <= 16'h0000;
      else if (frame_end) frame_cnt <= frame_cnt + 16'h0001;
   end

`ifdef FILTER_STATS_EN
   logic [PIX_W-1:0] acc_max, next_max;
   logic [15:0]      acc_sat, next_sat;
   logic             is_max;

   assign is_max = (filt == MAX);

   // The sof beat restarts the accumulators instead of folding into the old frame.
   always_comb begin
      next_max = acc_max;
      next_sat = acc_sat;
      if (sof_beat) begin
         next_max = filt;
         next_sat = {15'h0000, is_max};
      end else begin
         if (filt > acc_max) next_max = filt;
         if (is_max && (acc_sat != 16'hFFFF)) next_sat = acc_sat + 16'h0001;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_max  <= '0;
         acc_sat  <= 16'h0000;
         stat_max <= '0;
         stat_sat <= 16'h0000;
      end else if (accept) begin
         acc_max <= next_max;
         acc_sat <= next_sat;
         if (frame_end) begin
            stat_max <= next_max;
            stat_sat <= next_sat;
         end
      end
   end
`endif

endmodule

// File: tb/tb_filter_stream_select.sv
// Self-checking bench for filter_stream_select with a 4x2 frame and a pixel-index based reference model.
module tb_filter_stream_select;

   localparam int W = 4;
   localparam int H = 2;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] mode;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       out_sof, out_eol, out_eof;
   logic       busy;
   logic [15:0] frame_cnt;
   logic [7:0]  stat_max;
   logic [15:0] stat_sat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   filter_stream_select #(
      .IMG_W(W), .IMG_H(H), .PIX_W(8), .THRESH(128), .BRIGHT_OFS(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mode(mode),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .out_sof(out_sof),
      .out_eol(out_eol),
      .out_eof(out_eof),
      .busy(busy),
      .frame_cnt(frame_cnt)
`ifdef FILTER_STATS_EN
      ,
      .stat_max(stat_max),
      .stat_sat(stat_sat)
`endif
   );

`ifndef FILTER_STATS_EN
   assign stat_max = 8'h00;
   assign stat_sat = 16'h0000;
`endif

   // Reference model: position in frame by linear pixel index.
   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       eol;
      logic       eof;
   } exp_t;

   exp_t       exp_q[$];
   int         m_idx, m_frames;
   logic [1:0] m_mode;
   int         cur_max, cur_sat, st_max, st_sat;

   function automatic logic [7:0] ref_filter(input logic [7:0] p, input logic [1:0] m);
      int v;
      case (m)
         2'd0:    v = int'(p);
         2'd1:    v = 255 - int'(p);
         2'd2:    v = (int'(p) >= 128) ? 255 : 0;
         default: v = (int'(p) + 32 > 255) ? 255 : int'(p) + 32;
      endcase
      return v[7:0];
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      m_idx = 0; m_frames = 0; m_mode = 2'd0;
      cur_max = 0; cur_sat = 0; st_max = 0; st_sat = 0;
   endfunction

   function automatic void model_beat(input logic [7:0] p, input logic [1:0] m);
      exp_t e;
      int   f;
      if (m_idx == 0) m_mode = m;
      f = int'(ref_filter(p, m_mode));
      e.d   = f[7:0];
      e.sof = (m_idx == 0);
      e.eol = ((m_idx % W) == W - 1);
      e.eof = (m_idx == N - 1);
      if (m_idx == 0) begin
         cur_max = f;
         cur_sat = 0;
      end else if (f > cur_max) begin
         cur_max = f;
      end
      if (f == 255 && cur_sat < 65535) cur_sat++;
      exp_q.push_back(e);
      m_idx++;
      if (m_idx == N) begin
         m_idx    = 0;
         m_frames = (m_frames + 1) % 65536;
         st_max   = cur_max;
         st_sat   = cur_sat;
      end
   endfunction

   task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] m, input logic r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      mode      = m;
      out_ready = r;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; mode = 2'd0; out_ready = 1'b1;
      model_reset();
      #23;
      checks++;
      if ({out_valid, out_data, out_sof, out_eol, out_eof, busy, frame_cnt} !== 29'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b d=%h sof=%b eol=%b eof=%b busy=%b fc=%0d required all zero",
                  out_valid, out_data, out_sof, out_eol, out_eof, busy, frame_cnt);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b required 1", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      exp_t e;
      for (int i = 0; i < N + 2; i++) begin
         cycle(i < N, 8'(i), 2'd0, 1'b1);
         if (i >= 1 && i <= N) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i - 1)) begin
               errors++;
               $display("FAIL basic_latency cycle %0d got v=%b d=%h required v=1 d=%h", i, out_valid, out_data, 8'(i - 1));
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL basic_extra got d=%h required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eol, out_eof} !== {e.d, e.sof, e.eol, e.eof}) begin
                  errors++;
                  $display("FAIL basic_pix got %h %b%b%b required %h %b%b%b",
                           out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
               end
            end
         end
         if (in_valid && in_ready) model_beat(in_data, mode);
      end
      checks++;
      if (frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL basic_frame_cnt got %0d required 1", frame_cnt);
      end
   endtask

   task automatic test_filters();
      logic [7:0] pix[3*N];
      logic [1:0] md;
      exp_t       e;
      pix = '{8'h00, 8'h7F, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'hFE,
              8'd127, 8'd128, 8'h00, 8'hFF, 8'h7E, 8'h81, 8'h10, 8'hF0,
              8'hF0, 8'h10, 8'hDF, 8'hE0, 8'h00, 8'hFF, 8'h40, 8'hC0};
      for (int i = 0; i < 3 * N + 2; i++) begin
         md = (i < N) ? 2'd1 : (i < 2 * N) ? 2'd2 : 2'd3;
         cycle(i < 3 * N, (i < 3 * N) ? pix[i] : 8'h00, md, 1'b1);
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL filter_extra got d=%h required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eol, out_eof} !== {e.d, e.sof, e.eol, e.eof}) begin
                  errors++;
                  $display("FAIL filter_pix got %h %b%b%b required %h %b%b%b",
                           out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
               end
            end
         end
         if (in_valid && in_ready) model_beat(in_data, mode);
      end
   endtask

   task automatic test_mode_lock();
      exp_t e;
      for (int i = 0; i < 2 * N + 2; i++) begin
         cycle(i < 2 * N, 8'($urandom_range(0, 255)), (i < 2) ? 2'd1 : 2'd0, 1'b1);
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL lock_extra got d=%h required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eol, out_eof} !== {e.d, e.sof, e.eol, e.eof}) begin
                  errors++;
                  $display("FAIL lock_pix got %h %b%b%b required %h %b%b%b",
                           out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
               end
            end
         end
         if (in_valid && in_ready) model_beat(in_data, mode);
      end
   endtask

   task automatic test_stall_reset();
      logic [7:0] dv[8];
      logic       rv[8];
      logic [10:0] snap;
      exp_t       e;
      dv = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd13, 8'd13, 8'd13, 8'd14};
      rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      snap = '0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, dv[i], 2'd0, rv[i]);
         if (i >= 3 && i <= 5) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_ready got in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
            end
            if (i == 3) snap = {out_data, out_sof, out_eol, out_eof};
            else begin
               checks++;
               if ({out_data, out_sof, out_eol, out_eof} !== snap) begin
                  errors++;
                  $display("FAIL stall_stable got %h required %h", {out_data, out_sof, out_eol, out_eof}, snap);
               end
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stall_extra got d=%h required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eol, out_eof} !== {e.d, e.sof, e.eol, e.eof}) begin
                  errors++;
                  $display("FAIL stall_pix got %h %b%b%b required %h %b%b%b",
                           out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
               end
            end
         end
         if (in_valid && in_ready) model_beat(in_data, mode);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({out_valid, out_data, out_sof, out_eol, out_eof, busy, frame_cnt} !== 29'd0) begin
         errors++;
         $display("FAIL midframe_reset got v=%b d=%h markers=%b%b%b busy=%b fc=%0d required all zero",
                  out_valid, out_data, out_sof, out_eol, out_eof, busy, frame_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < N + 2; i++) begin
         cycle(i < N, 8'(8'h40 + i), 2'd0, 1'b1);
         if (i == 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== 8'h40) begin
               errors++;
               $display("FAIL post_reset_sof got v=%b sof=%b d=%h required 1 1 40", out_valid, out_sof, out_data);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL post_reset_extra got d=%h required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eol, out_eof} !== {e.d, e.sof, e.eol, e.eof}) begin
                  errors++;
                  $display("FAIL post_reset_pix got %h %b%b%b required %h %b%b%b",
                           out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
               end
            end
         end
         if (in_valid && in_ready) model_beat(in_data, mode);
      end
      checks++;
      if (frame_cnt !== 16'd1) begin
         errors++;
         $display("FAIL post_reset_frame_cnt got %0d required 1", frame_cnt);
      end
   endtask

`ifdef FILTER_STATS_EN
   task automatic test_stats();
      logic [7:0] pix[N];
      exp_t       e;
      pix = '{8'hF0, 8'h10, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < N + 2; i++) begin
         cycle(i < N, (i < N) ? pix[i] : 8'h00, 2'd3, 1'b1);
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stats_extra got d=%h required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eol, out_eof} !== {e.d, e.sof, e.eol, e.eof}) begin
                  errors++;
                  $display("FAIL stats_pix got %h %b%b%b required %h %b%b%b",
                           out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
               end
            end
         end
         if (in_valid && in_ready) model_beat(in_data, mode);
      end
      checks++;
      if (stat_max !== 8'hFF || stat_sat !== 16'd2) begin
         errors++;
         $display("FAIL stats_frame got max=%h sat=%0d required max=ff sat=2", stat_max, stat_sat);
      end
   endtask
`endif

   task automatic test_random();
      exp_t        e;
      int          accepted;
      int          cyc;
      logic        was_stall;
      logic [10:0] snap;
      logic        v, r;
      accepted  = 0;
      cyc       = 0;
      was_stall = 1'b0;
      snap      = '0;
      while ((accepted < 6 * N || exp_q.size() != 0) && cyc < 3000) begin
         v = (accepted < 6 * N) && ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 3) != 0) || (accepted >= 6 * N);
         cycle(v, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), r);
         cyc++;
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL rand_in_ready got %b required %b", in_ready, !out_valid || out_ready);
         end
         if (was_stall) begin
            checks++;
            if (out_valid !== 1'b1 || {out_data, out_sof, out_eol, out_eof} !== snap) begin
               errors++;
               $display("FAIL rand_stall_hold got v=%b %h required v=1 %h", out_valid,
                        {out_data, out_sof, out_eol, out_eof}, snap);
            end
         end
         was_stall = out_valid && !out_ready;
         snap      = {out_data, out_sof, out_eol, out_eof};
         checks++;
         if (frame_cnt !== 16'(m_frames)) begin
            errors++;
            $display("FAIL rand_frame_cnt got %0d required %0d", frame_cnt, m_frames);
         end
`ifdef FILTER_STATS_EN
         checks++;
         if (stat_max !== 8'(st_max) || stat_sat !== 16'(st_sat)) begin
            errors++;
            $display("FAIL rand_stats got max=%h sat=%0d required max=%h sat=%0d", stat_max, stat_sat, 8'(st_max), st_sat);
         end
`endif
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra got d=%h required no output", out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_data, out_sof, out_eol, out_eof} !== {e.d, e.sof, e.eol, e.eof}) begin
                  errors++;
                  $display("FAIL rand_pix got %h %b%b%b required %h %b%b%b",
                           out_data, out_sof, out_eol, out_eof, e.d, e.sof, e.eol, e.eof);
               end
            end
         end
         if (in_valid && in_ready) begin
            model_beat(in_data, mode);
            accepted++;
         end
      end
      checks++;
      if (cyc >= 3000) begin
         errors++;
         $display("FAIL rand_timeout got %0d beats accepted required %0d", accepted, 6 * N);
      end
      checks++;
      if (frame_cnt !== 16'(m_frames)) begin
         errors++;
         $display("FAIL rand_final_frame_cnt got %0d required %0d", frame_cnt, m_frames);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filters();
      test_mode_lock();
      test_stall_reset();
`ifdef FILTER_STATS_EN
      test_stats();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
